alu_mdu: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Keeps the existing ADD/SUB/PASS-B/SLTU encodings, adds logic and signed-compare ops, and adds an iterative multiply/divide unit (RISC-V M-style results).
- Sits in the execute stage. A start/done handshake lets the control unit stall while busy.

---
 rtl/alu_mdu.sv | 169 ++++++++++++++++
 tb/tb_alu_mdu.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// Execute-stage ALU with an iterative multiply/divide unit and a start/done handshake.
// Define ALU_MDU_SIGNED_EN to enable MULH/DIV/REM; otherwise those codes return 0 in one cycle.
module alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    count;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] hi, lo, divisor;
    logic [WIDTH-1:0] hi_next, lo_next, a_mag, b_mag, alu_res, final_res;
    logic [WIDTH:0]   step_sum;
    logic             accept, iter_op, mul_q;

    assign accept = start && (state != CALC);
    assign busy   = (state == CALC);
    assign zero   = (result == '0);

`ifdef ALU_MDU_SIGNED_EN
    logic sign_op, neg_next, neg_q;

    assign iter_op = op[3] && (op != 4'b1111);
    assign mul_q   = (op_q[3:1] == 3'b100) || (op_q == 4'b1100);

    // Signed ops iterate on magnitudes; neg_q remembers whether to negate at the end.
    always_comb begin
        sign_op = (op == 4'b1100) || (op == 4'b1101) || (op == 4'b1110);
        a_mag   = (sign_op && src_a[WIDTH-1]) ? -src_a : src_a;
        b_mag   = (sign_op && src_b[WIDTH-1]) ? -src_b : src_b;
        case (op)
            4'b1100: neg_next = src_a[WIDTH-1] ^ src_b[WIDTH-1];
            4'b1101: neg_next = (src_a[WIDTH-1] ^ src_b[WIDTH-1]) && (src_b != '0);
            4'b1110: neg_next = src_a[WIDTH-1];
            default: neg_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            neg_q <= 1'b0;
        else if (accept)
            neg_q <= neg_next;
    end
`else
    assign iter_op = (op[3:2] == 2'b10);
    assign mul_q   = (op_q[3:1] == 3'b100);
    assign a_mag   = src_a;
    assign b_mag   = src_b;
`endif

    always_comb begin
        alu_res = '0;
        case (op)
            4'b0000: alu_res = src_a + src_b;
            4'b0001: alu_res = src_a - src_b;
            4'b0010: alu_res = src_b;
            4'b0011: alu_res = WIDTH'(src_a < src_b);
            4'b0100: alu_res = WIDTH'($signed(src_a) < $signed(src_b));
            4'b0101: alu_res = src_a & src_b;
            4'b0110: alu_res = src_a | src_b;
            4'b0111: alu_res = src_a ^ src_b;
            default: alu_res = '0;
        endcase
    end

    // One iteration: {hi,lo} is the product (multiplier in lo) or {remainder,quotient}.
    always_comb begin
        hi_next  = hi;
        lo_next  = lo;
        step_sum = '0;
        if (mul_q) begin
            step_sum = {1'b0, hi} + (lo[0] ? {1'b0, divisor} : '0);
            {hi_next, lo_next} = {step_sum, lo[WIDTH-1:1]};
        end else begin
            step_sum = {hi, lo[WIDTH-1]} - {1'b0, divisor};
            if (!step_sum[WIDTH]) begin
                hi_next = step_sum[WIDTH-1:0];
                lo_next = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_next = {hi[WIDTH-2:0], lo[WIDTH-1]};
                lo_next = {lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        final_res = '0;
        case (op_q)
            4'b1000, 4'b1010: final_res = lo_next;
            4'b1001, 4'b1011: final_res = hi_next;
`ifdef ALU_MDU_SIGNED_EN
            4'b1100: final_res = neg_q ? (~hi_next + WIDTH'(lo_next == '0)) : hi_next;
            4'b1101: final_res = neg_q ? -lo_next : lo_next;
            4'b1110: final_res = neg_q ? -hi_next : hi_next;
`endif
            default: final_res = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                state_next = IDLE;
                if (accept && iter_op)
                    state_next = CALC;
            end
            CALC: begin
                if (count == '0)
                    state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done    <= 1'b0;
            result  <= '0;
            hi      <= '0;
            lo      <= '0;
            divisor <= '0;
            op_q    <= '0;
            count   <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                op_q    <= op;
                count   <= CW'(WIDTH - 1);
                hi      <= '0;
                lo      <= a_mag;
                divisor <= b_mag;
                if (!iter_op) begin
                    result <= alu_res;
                    done   <= 1'b1;
                end
            end else if (state == CALC) begin
                hi    <= hi_next;
                lo    <= lo_next;
                count <= count - 1'b1;
                if (count == '0) begin
                    result <= final_res;
                    done   <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu (WIDTH=32) against an arithmetic reference model.
// Honours ALU_MDU_SIGNED_EN the same way the design does.
module tb_alu_mdu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = '0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        busy, done, zero;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    alu_mdu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .busy(busy), .done(done), .result(result), .zero(zero)
    );

    always #5 clk = ~clk;

    // Reference results straight from the arithmetic definition of each op.
    function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] pu;
        longint sa, sb, ps;
        pu = {32'b0, a} * {32'b0, b};
        sa = $signed(a);
        sb = $signed(b);
        ps = sa * sb;
        case (o)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return b;
            4'd3:  return (a < b) ? 32'd1 : 32'd0;
            4'd4:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd5:  return a & b;
            4'd6:  return a | b;
            4'd7:  return a ^ b;
            4'd8:  return pu[31:0];
            4'd9:  return pu[63:32];
            4'd10: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd11: return (b == 0) ? a : a % b;
`ifdef ALU_MDU_SIGNED_EN
            4'd12: return ps[63:32];
            4'd13: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            4'd14: return (b == 0) ? a : 32'(sa % sb);
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_latency(input logic [3:0] o);
`ifdef ALU_MDU_SIGNED_EN
        return (o >= 4'd8 && o != 4'd15) ? 33 : 1;
`else
        return (o >= 4'd8 && o <= 4'd11) ? 33 : 1;
`endif
    endfunction

    // Issues one op and waits (bounded) for done, sampling on negedges.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic zr, output int lat, output int busy_cycles);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_cycles = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            lat++;
        end
        res = result;
        zr  = zero;
    endtask

    task automatic test_reset();
        int seen;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, result, zero} !== {1'b0, 1'b0, 32'd0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL reset_state: got busy=%b done=%b result=%h zero=%b expected 0 0 00000000 1", busy, done, result, zero);
        end
        // abort a DIVU mid-flight
        start = 1'b1; op = 4'd10; src_a = 32'd100; src_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, result} !== {1'b0, 1'b0, 32'd0}) begin
            errors++;
            $display("[TB] FAIL reset_abort: got busy=%b done=%b result=%h expected 0 0 00000000", busy, done, result);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("[TB] FAIL reset_no_done: got %0d active cycles expected 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [4] = '{4'd0, 4'd1, 4'd4, 4'd3};
        logic [31:0] as  [4] = '{32'd5, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs  [4] = '{32'd7, 32'd3, 32'd1, 32'd1};
        logic [31:0] exp;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                exp = model(ops[i-1], as[i-1], bs[i-1]);
                checks++;
                if ({done, result, zero} !== {1'b1, exp, exp == 32'd0}) begin
                    errors++;
                    $display("[TB] FAIL b2b_%0d: got done=%b result=%h zero=%b expected 1 %h %b", i - 1, done, result, zero, exp, exp == 32'd0);
                end
            end
            if (i < 4) begin
                start = 1'b1; op = ops[i]; src_a = as[i]; src_b = bs[i];
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_done_drop: got done=%b expected 0", done);
        end
    endtask

    task automatic test_muldiv();
        logic [3:0]  ops [6] = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd10, 4'd11};
        logic [31:0] as  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100, 32'd9, 32'd9};
        logic [31:0] bs  [6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0};
        logic [31:0] exp [6] = '{32'hFFFF_FFFE, 32'h1, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd9};
        logic [31:0] res;
        logic zr;
        int lat, bc;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], as[i], bs[i], res, zr, lat, bc);
            checks++;
            if (res !== exp[i]) begin
                errors++;
                $display("[TB] FAIL muldiv_%0d_result: got %h expected %h", i, res, exp[i]);
            end
            checks++;
            if (lat !== 33 || bc !== 32) begin
                errors++;
                $display("[TB] FAIL muldiv_%0d_timing: got latency %0d busy %0d expected 33 32", i, lat, bc);
            end
        end
    endtask

    task automatic test_ignore_while_busy();
        int extra;
        @(negedge clk);
        start = 1'b1; op = 4'd10; src_a = 32'd100; src_b = 32'd7;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            start = 1'b1;
            op = 4'($urandom_range(8, 11));
            src_a = $urandom;
            src_b = $urandom;
            checks++;
            if ({busy, done} !== 2'b10) begin
                errors++;
                $display("[TB] FAIL ignore_busy_%0d: got busy=%b done=%b expected 1 0", k, busy, done);
            end
        end
        @(negedge clk);
        checks++;
        if ({done, result} !== {1'b1, 32'd14}) begin
            errors++;
            $display("[TB] FAIL ignore_result: got done=%b result=%h expected 1 0000000e", done, result);
        end
        op = 4'd0; src_a = 32'd1; src_b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({done, result} !== {1'b1, 32'd3}) begin
            errors++;
            $display("[TB] FAIL accept_in_done: got done=%b result=%h expected 1 00000003", done, result);
        end
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("[TB] FAIL ignore_extra_done: got %0d done pulses expected 0", extra);
        end
    endtask

    task automatic test_signed();
        logic [3:0]  ops [5] = '{4'd13, 4'd14, 4'd13, 4'd14, 4'd12};
        logic [31:0] as  [5] = '{-32'sd7, -32'sd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] bs  [5] = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
`ifdef ALU_MDU_SIGNED_EN
        logic [31:0] exp [5] = '{-32'sd3, -32'sd1, 32'h8000_0000, 32'd0, 32'd0};
        int exp_lat = 33;
`else
        logic [31:0] exp [5] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        int exp_lat = 1;
`endif
        logic [31:0] res;
        logic zr;
        int lat, bc;
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], as[i], bs[i], res, zr, lat, bc);
            checks++;
            if (res !== exp[i] || lat !== exp_lat) begin
                errors++;
                $display("[TB] FAIL signed_%0d: got %h latency %0d expected %h latency %0d", i, res, lat, exp[i], exp_lat);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0]  o;
        logic [31:0] a, b, res, exp;
        logic zr;
        int lat, bc;
        for (int i = 0; i < 60; i++) begin
            o = 4'($urandom_range(0, 15));
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = b & 32'hFF;
            exp = model(o, a, b);
            run_op(o, a, b, res, zr, lat, bc);
            checks++;
            if (res !== exp || zr !== (exp == 32'd0) || lat !== model_latency(o)) begin
                errors++;
                $display("[TB] FAIL random_%0d op=%0d a=%h b=%h: got %h zero=%b latency %0d expected %h zero=%b latency %0d",
                         i, o, a, b, res, zr, lat, exp, exp == 32'd0, model_latency(o));
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_muldiv();
        test_ignore_while_busy();
        test_signed();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
